// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the BLE link transmitter and command receiver.
//   tx_state_t               : transmitter FSM states (IDLE, TRANSMIT)
//   UART_BAUD_DIV_50M_19200  : clk cycles per bit for 50 MHz / 19200 baud
//   frame_bits()             : bit periods per frame, 10 (8N1) or 11 (8E1)
//   even_parity()            : even-parity bit of a data byte
// Optional feature macro: UART_TX_PARITY_EN (selects 8E1 framing).
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } tx_state_t;

    localparam int UART_BAUD_DIV_50M_19200 = 2604;

    // Bit periods per frame: start + 8 data (+ parity) + stop.
    function automatic logic [3:0] frame_bits();
`ifdef UART_TX_PARITY_EN
        return 4'd11;
`else
        return 4'd10;
`endif
    endfunction

    // Even parity: the extra bit makes the count of ones in data+parity even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Serial transmitter for the BLE link. On an accepted trmt strobe it sends one
// byte LSB first (8N1, or 8E1 when UART_TX_PARITY_EN is defined) and then
// raises tx_done, which stays high until the next accepted strobe.
// Parameters:
//   BAUD_DIV  clk cycles per bit period (legal 16..4095)
// Ports:
//   clk      in   system clock, single domain
//   rst      in   asynchronous active-high reset
//   trmt     in   1-cycle start strobe, only honoured while idle
//   tx_data  in   byte to send, captured on the edge that accepts trmt
//   TX       out  serial line, idles high, driven straight from a flop
//   tx_done  out  set when the stop bit completes
//   busy     out  high from accept to the end of the stop bit
// Optional feature macro: UART_TX_PARITY_EN (even-parity bit before stop).
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV_50M_19200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       busy
);

    localparam logic [3:0]        FRAME_BITS = frame_bits();
    localparam int                SHIFT_W    = int'(frame_bits());
    localparam int                BAUD_W     = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(BAUD_DIV - 1);
    localparam logic [3:0]        LAST_BIT   = FRAME_BITS - 4'd1;

    tx_state_t            state_r;
    tx_state_t            state_s;
    logic [SHIFT_W-1:0]   shift_r;
    logic [SHIFT_W-1:0]   shift_s;
    logic [SHIFT_W-1:0]   load_s;
    logic [BAUD_W-1:0]    baud_cnt_r;
    logic [BAUD_W-1:0]    baud_cnt_s;
    logic [3:0]           bit_cnt_r;
    logic [3:0]           bit_cnt_s;
    logic                 tx_done_r;
    logic                 tx_done_s;
    logic                 busy_r;
    logic                 busy_s;

    // Frame image to load on accept; bit 0 goes out first.
`ifdef UART_TX_PARITY_EN
    assign load_s = {1'b1, even_parity(tx_data), tx_data, 1'b0};
`else
    assign load_s = {1'b1, tx_data, 1'b0};
`endif

    // Next-state and next-register logic for the IDLE/TRANSMIT sequencer.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        baud_cnt_s = baud_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        tx_done_s  = tx_done_r;
        busy_s     = busy_r;
        case (state_r)
            IDLE: begin
                if (trmt) begin
                    shift_s    = load_s;
                    baud_cnt_s = '0;
                    bit_cnt_s  = 4'd0;
                    tx_done_s  = 1'b0;
                    busy_s     = 1'b1;
                    state_s    = TRANSMIT;
                end else begin
                    // Keep the line parked high between frames.
                    shift_s = '1;
                end
            end
            TRANSMIT: begin
                if (baud_cnt_r == BAUD_LAST) begin
                    // End of a bit period: present the next bit, ones fill in
                    // behind so the line returns high after the stop bit.
                    shift_s    = {1'b1, shift_r[SHIFT_W-1:1]};
                    baud_cnt_s = '0;
                    bit_cnt_s  = bit_cnt_r + 4'd1;
                    if (bit_cnt_r == LAST_BIT) begin
                        tx_done_s = 1'b1;
                        busy_s    = 1'b0;
                        state_s   = IDLE;
                    end else begin
                        state_s = TRANSMIT;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + BAUD_W'(1);
                end
            end
            default: begin
                state_s    = IDLE;
                shift_s    = '1;
                baud_cnt_s = '0;
                bit_cnt_s  = 4'd0;
                tx_done_s  = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // State, shift register, counters and status flags; reset parks TX high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= '1;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 4'd0;
            tx_done_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            baud_cnt_r <= baud_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            tx_done_r  <= tx_done_s;
            busy_r     <= busy_s;
        end
    end

    assign TX      = shift_r[0];
    assign tx_done = tx_done_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Bench for uart_tx: one instance at BAUD_DIV=16 checked every cycle against
// a bit-period timing model, plus one instance at the default divider.
// Build with UART_TX_PARITY_EN defined to exercise 8E1 framing.
// ---------------------------------------------------------------------------
module tb_uart_tx;
    import uart_pkg::*;

    localparam int B  = 16;
    localparam int BD = UART_BAUD_DIV_50M_19200;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] EXP_A5 = 11'b1_0_10100101_0;
    localparam logic [10:0] EXP_07 = 11'b1_1_00000111_0;
    localparam logic [10:0] EXP_3C = 11'b1_0_00111100_0;
    localparam logic [10:0] EXP_00 = 11'b1_0_00000000_0;
    localparam logic [10:0] EXP_55 = 11'b1_0_01010101_0;
`else
    localparam int NB = 10;
    localparam logic [10:0] EXP_A5 = 11'b0_1_10100101_0;
    localparam logic [10:0] EXP_07 = 11'b0_1_00000111_0;
    localparam logic [10:0] EXP_3C = 11'b0_1_00111100_0;
    localparam logic [10:0] EXP_00 = 11'b0_1_00000000_0;
    localparam logic [10:0] EXP_55 = 11'b0_1_01010101_0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trmt = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_line, tx_done, busy;
    logic       trmt_d = 1'b0;
    logic [7:0] tx_data_d = 8'h00;
    logic       tx_line_d, tx_done_d, busy_d;

    int  n_checks = 0;
    int  n_pass   = 0;
    time t_acc;

    always #5 clk = ~clk;

    uart_tx #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .trmt(trmt), .tx_data(tx_data),
        .TX(tx_line), .tx_done(tx_done), .busy(busy)
    );

    uart_tx dut_d (
        .clk(clk), .rst(rst), .trmt(trmt_d), .tx_data(tx_data_d),
        .TX(tx_line_d), .tx_done(tx_done_d), .busy(busy_d)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Timing model: a frame is a list of bits, each held B clocks from accept.
    logic [10:0] m_bits = 11'h7FF;
    int          m_cnt  = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == NB * B) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (trmt) begin
`ifdef UART_TX_PARITY_EN
            m_bits <= {1'b1, ^tx_data, tx_data, 1'b0};
`else
            m_bits <= {2'b11, tx_data, 1'b0};
`endif
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end
    end

    always @(negedge clk) begin
        check("model_tx", {31'd0, tx_line}, {31'd0, (m_busy ? m_bits[m_cnt / B] : 1'b1)});
        check("model_busy", {31'd0, busy}, {31'd0, m_busy});
        check("model_done", {31'd0, tx_done}, {31'd0, m_done});
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d);
        trmt = 1'b1; tx_data = d;
        @(negedge clk);
        trmt = 1'b0;
        t_acc = $time;
    endtask

    task automatic send_d(input logic [7:0] d);
        trmt_d = 1'b1; tx_data_d = d;
        @(negedge clk);
        trmt_d = 1'b0;
        t_acc = $time;
    endtask

    // Sample the line in the middle of every bit period of the frame.
    task automatic sample_frame(input string nm, input bit which, input int bd,
                                input logic [10:0] exp);
        repeat (bd / 2) @(negedge clk);
        for (int k = 0; k < NB; k++) begin
            if (k != 0) repeat (bd) @(negedge clk);
            check($sformatf("%s_bit%0d", nm, k), {31'd0, (which ? tx_line_d : tx_line)},
                  {31'd0, exp[k]});
        end
    endtask

    task automatic wait_done(input string nm, input bit which, input int exp_clks);
        int n = 0;
        while ((which ? tx_done_d : tx_done) !== 1'b1 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_done_clks"}, int'(($time - t_acc) / 10), exp_clks);
        check({nm, "_busy_low"}, {31'd0, (which ? busy_d : busy)}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx_line}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, tx_done}, 32'd0);
        check("rst_tx_d", {31'd0, tx_line_d}, 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: basic frame
        send(8'hA5);
        check("t1_start", {31'd0, tx_line}, 32'd0);
        sample_frame("t1", 1'b0, B, EXP_A5);
        wait_done("t1", 1'b0, NB * B);

        // 2: strobe while busy is ignored
        repeat (4) @(negedge clk);
        send(8'hA5);
        repeat (3 * B + 5) @(negedge clk);
        trmt = 1'b1; tx_data = 8'hFF;
        @(negedge clk);
        trmt = 1'b0;
        wait_done("t2", 1'b0, NB * B);
        repeat (40) @(negedge clk);
        check("t2_no_refire_busy", {31'd0, busy}, 32'd0);
        check("t2_done_held", {31'd0, tx_done}, 32'd1);
        check("t2_idle_line", {31'd0, tx_line}, 32'd1);

        // 3: back-to-back frames
        send(8'h00);
        sample_frame("t3a", 1'b0, B, EXP_00);
        wait_done("t3a", 1'b0, NB * B);
        send(8'h55);
        check("t3_b2b_start", {31'd0, tx_line}, 32'd0);
        check("t3_done_cleared", {31'd0, tx_done}, 32'd0);
        wait_done("t3b", 1'b0, NB * B);

        // 4: reset mid-frame during a zero data bit (d6 of 0x3C)
        repeat (3) @(negedge clk);
        send(8'h3C);
        repeat (7 * B + 4) @(negedge clk);
        check("t4_pre_rst_tx", {31'd0, tx_line}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_tx", {31'd0, tx_line}, 32'd1);
        check("t4_rst_busy", {31'd0, busy}, 32'd0);
        check("t4_rst_done", {31'd0, tx_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'h3C);
        sample_frame("t4", 1'b0, B, EXP_3C);
        wait_done("t4", 1'b0, NB * B);

        // 5: parity-sensitive bytes
        send(8'hA5);
        sample_frame("t5a", 1'b0, B, EXP_A5);
        wait_done("t5a", 1'b0, NB * B);
        send(8'h07);
        sample_frame("t5b", 1'b0, B, EXP_07);
        wait_done("t5b", 1'b0, NB * B);

        // 6: default divider, one byte decoded mid-bit
        repeat (2) @(negedge clk);
        send_d(8'h55);
        check("t6_start", {31'd0, tx_line_d}, 32'd0);
        sample_frame("t6", 1'b1, BD, EXP_55);
        wait_done("t6", 1'b1, NB * BD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
